// File: rtl/cellrv32_mtime_sched.sv
// rtl/cellrv32_mtime_sched.sv - multiplexes NUM_CH virtual deadlines onto the single MTIME compare register
module cellrv32_mtime_sched #(
    parameter int NUM_CH = 4
) (
    input  logic        clk_i,
    input  logic        rstn_i,
    input  logic        sel_i,
    input  logic [6:0]  addr_i,
    input  logic        rden_i,
    input  logic        wren_i,
    input  logic [31:0] data_i,
    output logic [31:0] data_o,
    output logic        ack_o,
    output logic [31:0] m_addr_o,
    output logic        m_wren_o,
    output logic [31:0] m_data_o,
    input  logic        m_ack_i,
    input  logic        mtime_irq_i,
    output logic        irq_o
);

    localparam logic [31:0] mtime_cmp_lo_addr_c = 32'hFFFF_FF98;
    localparam logic [31:0] mtime_cmp_hi_addr_c = 32'hFFFF_FF9C;
    localparam int IW = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

    typedef enum logic [2:0] {
        S_IDLE, S_SCAN, S_WR_HMAX, S_WR_LO, S_WR_HI, S_SETTLE, S_ARMED
    } state_t;

    state_t state_q, state_d;

    logic [NUM_CH-1:0] enable_q, pending_q;
    logic [31:0]       dl_lo_q [NUM_CH];
    logic [31:0]       dl_hi_q [NUM_CH];
    logic              dirty_q;
    logic [IW-1:0]     scan_idx_q, cand_idx_q, win_idx_q;
    logic [63:0]       cand_q, target_q;
    logic              cand_vld_q, win_vld_q;
    logic [1:0]        settle_q;

    // host decode
    logic [4:0]        word;
    logic              wr_en, rd_en, wr_enable, wr_pending, host_dirty, busy;
    logic [NUM_CH-1:0] dl_lo_wr, dl_hi_wr;
    logic [31:0]       rdata;
    logic              unused_addr;

    assign word        = addr_i[6:2];
    assign unused_addr = &{1'b0, addr_i[1:0]};
    assign wr_en       = sel_i & wren_i;
    assign rd_en       = sel_i & rden_i;
    assign wr_enable   = wr_en && (word == 5'd0);
    assign wr_pending  = wr_en && (word == 5'd1);
    assign busy        = (state_q != S_IDLE) && (state_q != S_ARMED);

    always_comb begin
        dl_lo_wr = '0;
        dl_hi_wr = '0;
        for (int n = 0; n < NUM_CH; n++) begin
            dl_lo_wr[n] = wr_en && (word == 5'(4 + 2 * n));
            dl_hi_wr[n] = wr_en && (word == 5'(5 + 2 * n));
        end
    end

    assign host_dirty = wr_enable | (|dl_lo_wr) | (|dl_hi_wr);

    always_comb begin
        rdata = '0;
        if (word == 5'd0) begin
            rdata[NUM_CH-1:0] = enable_q;
        end else if (word == 5'd1) begin
            rdata[NUM_CH-1:0] = pending_q;
        end else if (word == 5'd2) begin
            rdata[7:0] = {win_vld_q, 3'(win_idx_q), 3'b000, busy};
        end
        for (int n = 0; n < NUM_CH; n++) begin
            if (word == 5'(4 + 2 * n)) rdata = dl_lo_q[n];
            if (word == 5'(5 + 2 * n)) rdata = dl_hi_q[n];
        end
    end

    // scan datapath: one channel per cycle, strict less-than keeps the lowest index on ties
    logic [63:0] cur_dl;
    logic        take, last;

    assign cur_dl = {dl_hi_q[scan_idx_q], dl_lo_q[scan_idx_q]};
    assign take   = enable_q[scan_idx_q] && (!cand_vld_q || (cur_dl < cand_q));
    assign last   = (scan_idx_q == IW'(NUM_CH - 1));

    // expiry: the winner plus every enabled channel sharing its deadline
    logic              fire;
    logic [NUM_CH-1:0] hw_set;

    assign fire = (state_q == S_ARMED) && !dirty_q && mtime_irq_i && win_vld_q;

    always_comb begin
        hw_set = '0;
        for (int n = 0; n < NUM_CH; n++) begin
            hw_set[n] = fire && ((enable_q[n] && ({dl_hi_q[n], dl_lo_q[n]} == target_q)) ||
                                 (win_idx_q == IW'(n)));
        end
    end

    logic dirty_clr, enter_scan;

    always_comb begin
        state_d   = state_q;
        dirty_clr = 1'b0;
        m_wren_o  = 1'b0;
        m_addr_o  = '0;
        m_data_o  = '0;
        unique case (state_q)
            S_IDLE: begin
                if (dirty_q) begin
                    dirty_clr = 1'b1;
                    state_d   = S_SCAN;
                end
            end
            S_SCAN: begin
                if (last) state_d = S_WR_HMAX;
            end
            S_WR_HMAX: begin
                // park cmp_hi at max so the half-written compare can never match early
                m_wren_o = 1'b1;
                m_addr_o = mtime_cmp_hi_addr_c;
                m_data_o = 32'hFFFF_FFFF;
                if (m_ack_i) state_d = S_WR_LO;
            end
            S_WR_LO: begin
                m_wren_o = 1'b1;
                m_addr_o = mtime_cmp_lo_addr_c;
                m_data_o = target_q[31:0];
                if (m_ack_i) state_d = S_WR_HI;
            end
            S_WR_HI: begin
                m_wren_o = 1'b1;
                m_addr_o = mtime_cmp_hi_addr_c;
                m_data_o = target_q[63:32];
                if (m_ack_i) state_d = S_SETTLE;
            end
            S_SETTLE: begin
                if (settle_q == 2'd2) state_d = S_ARMED;
            end
            S_ARMED: begin
                if (dirty_q) begin
                    dirty_clr = 1'b1;
                    state_d   = S_SCAN;
                end else if (mtime_irq_i && win_vld_q) begin
                    state_d = S_SCAN;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign enter_scan = (state_d == S_SCAN) && (state_q != S_SCAN);

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            state_q    <= S_IDLE;
            scan_idx_q <= '0;
            cand_idx_q <= '0;
            cand_q     <= '1;
            cand_vld_q <= 1'b0;
            target_q   <= '1;
            win_idx_q  <= '0;
            win_vld_q  <= 1'b0;
            settle_q   <= '0;
        end else begin
            state_q  <= state_d;
            settle_q <= (state_q == S_SETTLE) ? settle_q + 2'd1 : 2'd0;
            if (enter_scan) begin
                scan_idx_q <= '0;
                cand_idx_q <= '0;
                cand_q     <= '1;
                cand_vld_q <= 1'b0;
            end else if (state_q == S_SCAN) begin
                if (take) begin
                    cand_q     <= cur_dl;
                    cand_idx_q <= scan_idx_q;
                    cand_vld_q <= 1'b1;
                end
                if (last) begin
                    target_q  <= take ? cur_dl : cand_q;
                    win_idx_q <= take ? scan_idx_q : cand_idx_q;
                    win_vld_q <= take | cand_vld_q;
                end else begin
                    scan_idx_q <= scan_idx_q + 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            enable_q  <= '0;
            pending_q <= '0;
            dirty_q   <= 1'b1;
            data_o    <= '0;
            ack_o     <= 1'b0;
            irq_o     <= 1'b0;
            for (int n = 0; n < NUM_CH; n++) begin
                dl_lo_q[n] <= '0;
                dl_hi_q[n] <= '0;
            end
        end else begin
            enable_q  <= (wr_enable ? data_i[NUM_CH-1:0] : enable_q) & ~hw_set;
            // hardware set overrides a simultaneous W1C of the same bit
            pending_q <= (pending_q & ~(wr_pending ? data_i[NUM_CH-1:0] : '0)) | hw_set;
            dirty_q   <= (dirty_q & ~dirty_clr) | host_dirty;
            data_o    <= rd_en ? rdata : '0;
            ack_o     <= sel_i & (rden_i | wren_i);
            irq_o     <= |pending_q;
            for (int n = 0; n < NUM_CH; n++) begin
                if (dl_lo_wr[n]) dl_lo_q[n] <= data_i;
                if (dl_hi_wr[n]) dl_hi_q[n] <= data_i;
            end
        end
    end

endmodule

// File: tb/tb_cellrv32_mtime_sched.sv
// tb/tb_cellrv32_mtime_sched.sv - directed self-checking bench for cellrv32_mtime_sched
module tb_cellrv32_mtime_sched;

    localparam logic [31:0] HI   = 32'hFFFF_FF9C;
    localparam logic [31:0] LO   = 32'hFFFF_FF98;
    localparam logic [31:0] ONES = 32'hFFFF_FFFF;

    logic        clk_i = 1'b0;
    logic        rstn_i = 1'b0;
    logic        sel_i = 1'b0, rden_i = 1'b0, wren_i = 1'b0;
    logic [6:0]  addr_i = '0;
    logic [31:0] data_i = '0;
    logic [31:0] data_o, m_addr_o, m_data_o;
    logic        ack_o, m_wren_o, irq_o;
    logic        m_ack_i = 1'b1;
    logic        mtime_irq_i = 1'b0;

    int check_cnt = 0;
    int pass_cnt = 0;

    logic [31:0] log_addr[$];
    logic [31:0] log_data[$];
    int ack_delay = 0;
    int stable_err = 0;

    cellrv32_mtime_sched #(.NUM_CH(4)) dut (
        .clk_i(clk_i), .rstn_i(rstn_i), .sel_i(sel_i), .addr_i(addr_i),
        .rden_i(rden_i), .wren_i(wren_i), .data_i(data_i), .data_o(data_o),
        .ack_o(ack_o), .m_addr_o(m_addr_o), .m_wren_o(m_wren_o),
        .m_data_o(m_data_o), .m_ack_i(m_ack_i), .mtime_irq_i(mtime_irq_i),
        .irq_o(irq_o)
    );

    always #5 clk_i = ~clk_i;

    // MTIME-side responder: logs accepted writes and tracks output stability while waiting
    initial begin : master_model
        int cnt;
        logic [31:0] a0, d0;
        cnt = 0;
        a0 = '0;
        d0 = '0;
        forever begin
            @(negedge clk_i);
            if (ack_delay == 0) begin
                m_ack_i = 1'b1;
                cnt = 0;
                if (m_wren_o) begin
                    log_addr.push_back(m_addr_o);
                    log_data.push_back(m_data_o);
                end
            end else if (m_wren_o) begin
                if (cnt == 0) begin
                    a0 = m_addr_o;
                    d0 = m_data_o;
                end else if (m_addr_o !== a0 || m_data_o !== d0) begin
                    stable_err++;
                end
                if (cnt == ack_delay) begin
                    m_ack_i = 1'b1;
                    log_addr.push_back(m_addr_o);
                    log_data.push_back(m_data_o);
                    cnt = 0;
                end else begin
                    m_ack_i = 1'b0;
                    cnt++;
                end
            end else begin
                m_ack_i = 1'b0;
                cnt = 0;
            end
        end
    end

    task automatic host_write(input logic [6:0] a, input logic [31:0] d);
        @(negedge clk_i);
        sel_i = 1'b1; wren_i = 1'b1; addr_i = a; data_i = d;
        @(negedge clk_i);
        sel_i = 1'b0; wren_i = 1'b0;
    endtask

    task automatic host_read(input logic [6:0] a, output logic [31:0] d, output logic ak);
        @(negedge clk_i);
        sel_i = 1'b1; rden_i = 1'b1; addr_i = a;
        @(negedge clk_i);
        sel_i = 1'b0; rden_i = 1'b0;
        d = data_o;
        ak = ack_o;
    endtask

    task automatic wait_writes(input int n, input int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk_i);
            #1;
            if (log_addr.size() >= n) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic fire_irq();
        @(negedge clk_i);
        mtime_irq_i = 1'b1;
        @(negedge clk_i);
        mtime_irq_i = 1'b0;
    endtask

    task automatic test_reset();
        logic [31:0] ea[3], ed[3], rd;
        logic ak;
        bit ok;
        ea = '{HI, LO, HI};
        ed = '{ONES, ONES, ONES};
        rstn_i = 1'b0;
        repeat (3) @(negedge clk_i);
        check_cnt++;
        if ({m_wren_o, m_addr_o, m_data_o} !== 65'd0) $display("FAIL reset_master got %b/%h/%h want 0/0/0", m_wren_o, m_addr_o, m_data_o);
        else pass_cnt++;
        check_cnt++;
        if ({data_o, ack_o, irq_o} !== 34'd0) $display("FAIL reset_host got %h/%b/%b want 0/0/0", data_o, ack_o, irq_o);
        else pass_cnt++;
        log_addr.delete(); log_data.delete();
        rstn_i = 1'b1;
        wait_writes(3, 50, ok);
        check_cnt++;
        if (!ok) $display("FAIL reset_seq_timeout got %0d writes want 3", log_addr.size());
        else pass_cnt++;
        for (int i = 0; i < 3 && i < log_addr.size(); i++) begin
            check_cnt++;
            if (log_addr[i] !== ea[i] || log_data[i] !== ed[i]) $display("FAIL reset_wr%0d got %h:%h want %h:%h", i, log_addr[i], log_data[i], ea[i], ed[i]);
            else pass_cnt++;
        end
        repeat (8) @(negedge clk_i);
        check_cnt++;
        if (log_addr.size() != 3) $display("FAIL reset_wr_count got %0d want 3", log_addr.size());
        else pass_cnt++;
        host_read(7'h08, rd, ak);
        check_cnt++;
        if (rd !== 32'h0 || ak !== 1'b1) $display("FAIL reset_status got %h ack %b want 00000000 ack 1", rd, ak);
        else pass_cnt++;
        @(negedge clk_i);
        check_cnt++;
        if (ack_o !== 1'b0 || data_o !== 32'h0) $display("FAIL ack_single got ack %b data %h want 0/0", ack_o, data_o);
        else pass_cnt++;
    endtask

    task automatic test_winner();
        logic [31:0] ea[3], ed[3], rd;
        logic ak;
        int n;
        ea = '{HI, LO, HI};
        ed = '{ONES, 32'h80, 32'h0};
        log_addr.delete(); log_data.delete();
        host_write(7'h10, 32'h100);
        host_write(7'h20, 32'h80);
        host_write(7'h00, 32'h5);
        repeat (60) @(negedge clk_i);
        n = log_addr.size();
        check_cnt++;
        if (n < 3) $display("FAIL winner_wr_count got %0d want >=3", n);
        else pass_cnt++;
        for (int i = 0; i < 3 && n >= 3; i++) begin
            check_cnt++;
            if (log_addr[n-3+i] !== ea[i] || log_data[n-3+i] !== ed[i]) $display("FAIL winner_wr%0d got %h:%h want %h:%h", i, log_addr[n-3+i], log_data[n-3+i], ea[i], ed[i]);
            else pass_cnt++;
        end
        host_read(7'h08, rd, ak);
        check_cnt++;
        if (rd !== 32'hA0) $display("FAIL winner_status got %h want 000000a0", rd);
        else pass_cnt++;
        host_read(7'h20, rd, ak);
        check_cnt++;
        if (rd !== 32'h80) $display("FAIL dl_lo2_readback got %h want 00000080", rd);
        else pass_cnt++;
    endtask

    task automatic test_fire();
        logic [31:0] ea[3], ed[3], rd;
        logic ak;
        bit ok;
        ea = '{HI, LO, HI};
        ed = '{ONES, 32'h100, 32'h0};
        log_addr.delete(); log_data.delete();
        host_write(7'h00, 32'h5);
        wait_writes(3, 50, ok);
        check_cnt++;
        if (!ok) $display("FAIL fire_rearm_timeout got %0d writes want 3", log_addr.size());
        else pass_cnt++;
        // irq high for all three settle cycles, dropped once armed
        @(negedge clk_i);
        mtime_irq_i = 1'b1;
        repeat (3) @(negedge clk_i);
        mtime_irq_i = 1'b0;
        host_read(7'h04, rd, ak);
        check_cnt++;
        if (rd !== 32'h0) $display("FAIL settle_ignore got pending %h want 00000000", rd);
        else pass_cnt++;
        host_read(7'h08, rd, ak);
        check_cnt++;
        if (rd !== 32'hA0) $display("FAIL armed_status got %h want 000000a0", rd);
        else pass_cnt++;
        log_addr.delete(); log_data.delete();
        fire_irq();
        wait_writes(3, 50, ok);
        check_cnt++;
        if (!ok) $display("FAIL fire_seq_timeout got %0d writes want 3", log_addr.size());
        else pass_cnt++;
        for (int i = 0; i < 3 && i < log_addr.size(); i++) begin
            check_cnt++;
            if (log_addr[i] !== ea[i] || log_data[i] !== ed[i]) $display("FAIL fire_wr%0d got %h:%h want %h:%h", i, log_addr[i], log_data[i], ea[i], ed[i]);
            else pass_cnt++;
        end
        repeat (8) @(negedge clk_i);
        host_read(7'h04, rd, ak);
        check_cnt++;
        if (rd !== 32'h4) $display("FAIL fire_pending got %h want 00000004", rd);
        else pass_cnt++;
        host_read(7'h00, rd, ak);
        check_cnt++;
        if (rd !== 32'h1) $display("FAIL fire_enable got %h want 00000001", rd);
        else pass_cnt++;
        check_cnt++;
        if (irq_o !== 1'b1) $display("FAIL fire_irq_o got %b want 1", irq_o);
        else pass_cnt++;
        host_read(7'h08, rd, ak);
        check_cnt++;
        if (rd !== 32'h80) $display("FAIL fire_status got %h want 00000080", rd);
        else pass_cnt++;
    endtask

    task automatic test_tie();
        logic [31:0] ea[3], ed[3], rd;
        logic ak;
        bit ok;
        int n;
        host_write(7'h04, 32'h4);
        repeat (2) @(negedge clk_i);
        check_cnt++;
        if (irq_o !== 1'b0) $display("FAIL w1c_irq_o got %b want 0", irq_o);
        else pass_cnt++;
        log_addr.delete(); log_data.delete();
        host_write(7'h1C, 32'h1);
        host_write(7'h18, 32'h0);
        host_write(7'h2C, 32'h1);
        host_write(7'h28, 32'h0);
        host_write(7'h00, 32'hA);
        repeat (60) @(negedge clk_i);
        ea = '{HI, LO, HI};
        ed = '{ONES, 32'h0, 32'h1};
        n = log_addr.size();
        check_cnt++;
        if (n < 3) $display("FAIL tie_wr_count got %0d want >=3", n);
        else pass_cnt++;
        for (int i = 0; i < 3 && n >= 3; i++) begin
            check_cnt++;
            if (log_addr[n-3+i] !== ea[i] || log_data[n-3+i] !== ed[i]) $display("FAIL tie_wr%0d got %h:%h want %h:%h", i, log_addr[n-3+i], log_data[n-3+i], ea[i], ed[i]);
            else pass_cnt++;
        end
        host_read(7'h08, rd, ak);
        check_cnt++;
        if (rd !== 32'h90) $display("FAIL tie_status got %h want 00000090", rd);
        else pass_cnt++;
        log_addr.delete(); log_data.delete();
        fire_irq();
        wait_writes(3, 50, ok);
        ed = '{ONES, ONES, ONES};
        check_cnt++;
        if (!ok) $display("FAIL tie_disarm_timeout got %0d writes want 3", log_addr.size());
        else pass_cnt++;
        for (int i = 0; i < 3 && i < log_addr.size(); i++) begin
            check_cnt++;
            if (log_addr[i] !== ea[i] || log_data[i] !== ed[i]) $display("FAIL tie_disarm_wr%0d got %h:%h want %h:%h", i, log_addr[i], log_data[i], ea[i], ed[i]);
            else pass_cnt++;
        end
        repeat (8) @(negedge clk_i);
        host_read(7'h04, rd, ak);
        check_cnt++;
        if (rd !== 32'hA) $display("FAIL tie_pending got %h want 0000000a", rd);
        else pass_cnt++;
        host_read(7'h00, rd, ak);
        check_cnt++;
        if (rd !== 32'h0) $display("FAIL tie_enable got %h want 00000000", rd);
        else pass_cnt++;
        host_read(7'h08, rd, ak);
        check_cnt++;
        if (rd !== 32'h0) $display("FAIL tie_status_idle got %h want 00000000", rd);
        else pass_cnt++;
        log_addr.delete(); log_data.delete();
        @(negedge clk_i);
        mtime_irq_i = 1'b1;
        repeat (3) @(negedge clk_i);
        mtime_irq_i = 1'b0;
        repeat (10) @(negedge clk_i);
        check_cnt++;
        if (log_addr.size() != 0) $display("FAIL invalid_irq_writes got %0d want 0", log_addr.size());
        else pass_cnt++;
        host_read(7'h04, rd, ak);
        check_cnt++;
        if (rd !== 32'hA) $display("FAIL invalid_irq_pending got %h want 0000000a", rd);
        else pass_cnt++;
    endtask

    task automatic test_ack_delay();
        logic [31:0] ea[6], ed[6], rd;
        logic ak;
        bit ok;
        ea = '{HI, LO, HI, HI, LO, HI};
        ed = '{ONES, 32'h100, 32'h0, ONES, 32'h40, 32'h0};
        host_write(7'h04, 32'hA);
        @(negedge clk_i);
        ack_delay = 5;
        stable_err = 0;
        log_addr.delete(); log_data.delete();
        host_write(7'h00, 32'h1);
        wait_writes(1, 100, ok);
        check_cnt++;
        if (!ok) $display("FAIL slow_first_timeout got %0d writes want 1", log_addr.size());
        else pass_cnt++;
        host_write(7'h10, 32'h40);
        wait_writes(6, 300, ok);
        check_cnt++;
        if (!ok) $display("FAIL slow_seq_timeout got %0d writes want 6", log_addr.size());
        else pass_cnt++;
        for (int i = 0; i < 6 && i < log_addr.size(); i++) begin
            check_cnt++;
            if (log_addr[i] !== ea[i] || log_data[i] !== ed[i]) $display("FAIL slow_wr%0d got %h:%h want %h:%h", i, log_addr[i], log_data[i], ea[i], ed[i]);
            else pass_cnt++;
        end
        check_cnt++;
        if (stable_err != 0) $display("FAIL slow_stable got %0d changes want 0", stable_err);
        else pass_cnt++;
        repeat (10) @(negedge clk_i);
        ack_delay = 0;
        host_read(7'h08, rd, ak);
        check_cnt++;
        if (rd !== 32'h80) $display("FAIL slow_status got %h want 00000080", rd);
        else pass_cnt++;
    endtask

    task automatic test_w1c_collision();
        logic [31:0] rd;
        logic ak;
        host_write(7'h00, 32'h4);
        repeat (40) @(negedge clk_i);
        host_read(7'h08, rd, ak);
        check_cnt++;
        if (rd !== 32'hA0) $display("FAIL coll_status got %h want 000000a0", rd);
        else pass_cnt++;
        @(negedge clk_i);
        sel_i = 1'b1; wren_i = 1'b1; addr_i = 7'h04; data_i = 32'h4; mtime_irq_i = 1'b1;
        @(negedge clk_i);
        sel_i = 1'b0; wren_i = 1'b0; mtime_irq_i = 1'b0;
        host_read(7'h04, rd, ak);
        check_cnt++;
        if (rd !== 32'h4) $display("FAIL coll_pending got %h want 00000004", rd);
        else pass_cnt++;
        host_read(7'h00, rd, ak);
        check_cnt++;
        if (rd !== 32'h0) $display("FAIL coll_enable got %h want 00000000", rd);
        else pass_cnt++;
        host_write(7'h04, 32'h4);
        host_read(7'h04, rd, ak);
        check_cnt++;
        if (rd !== 32'h0) $display("FAIL w1c_pending got %h want 00000000", rd);
        else pass_cnt++;
        host_read(7'h0C, rd, ak);
        check_cnt++;
        if (rd !== 32'h0 || ak !== 1'b1) $display("FAIL unmapped_read got %h ack %b want 00000000 ack 1", rd, ak);
        else pass_cnt++;
    endtask

    task automatic test_reset_mid_write();
        logic [31:0] ed[3];
        bit seen, ok;
        ed = '{HI, LO, HI};
        host_write(7'h00, 32'h1);
        @(negedge clk_i);
        ack_delay = 5;
        host_write(7'h10, 32'h20);
        seen = 1'b0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk_i);
            if (m_wren_o) begin
                seen = 1'b1;
                break;
            end
        end
        check_cnt++;
        if (!seen) $display("FAIL midrst_wren_timeout got 0 want 1");
        else pass_cnt++;
        rstn_i = 1'b0;
        #1;
        check_cnt++;
        if (m_wren_o !== 1'b0 || m_addr_o !== 32'h0) $display("FAIL midrst_drop got %b/%h want 0/00000000", m_wren_o, m_addr_o);
        else pass_cnt++;
        ack_delay = 0;
        @(negedge clk_i);
        log_addr.delete(); log_data.delete();
        rstn_i = 1'b1;
        wait_writes(3, 50, ok);
        check_cnt++;
        if (!ok) $display("FAIL midrst_seq_timeout got %0d writes want 3", log_addr.size());
        else pass_cnt++;
        for (int i = 0; i < 3 && i < log_addr.size(); i++) begin
            check_cnt++;
            if (log_addr[i] !== ed[i] || log_data[i] !== ONES) $display("FAIL midrst_wr%0d got %h:%h want %h:%h", i, log_addr[i], log_data[i], ed[i], ONES);
            else pass_cnt++;
        end
    endtask

    initial begin
        test_reset();
        test_winner();
        test_fire();
        test_tie();
        test_ack_delay();
        test_w1c_collision();
        test_reset_mid_write();
        repeat (4) @(negedge clk_i);
        $display("%0d/%0d checks passed", pass_cnt, check_cnt);
        $finish;
    end

endmodule
